// File: rtl/ap_line_sequencer.sv
// ap_line_sequencer
// Expands repeat-counted pointer/data commands into single-step request
// pulses on the AP/data line and paces each step against the line's Ready.
// Optional feature macro: APSEQ_TIMEOUT_EN adds a watchdog that abandons a
// command when the line stays not-ready for TIMEOUT_CYCLES cycles.
module ap_line_sequencer #(
    parameter int COUNT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic [2:0]             CmdOp,
    input  logic [COUNT_WIDTH-1:0] CmdCount,
    output logic                   ApRequest,
    output logic                   DataRequest,
    output logic                   Dec,
    output logic                   Zero,
    input  logic                   LineReady,
    input  logic                   DataZero,
    output logic                   Done,
    output logic                   ZeroFlag,
    output logic                   Fault
);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_INC_DATA = 3'd1;
    localparam logic [2:0] OP_DEC_DATA = 3'd2;
    localparam logic [2:0] OP_INC_AP   = 3'd3;
    localparam logic [2:0] OP_DEC_AP   = 3'd4;
    localparam logic [2:0] OP_ZERO     = 3'd5;
    localparam logic [2:0] OP_TEST     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    // Parameter sanity: a zero-width count or watchdog limit is meaningless.
    if (COUNT_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ap_line_sequencer: COUNT_WIDTH and TIMEOUT_CYCLES must be >= 1");
    end

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   dec_q, dec_d;
    logic                   ap_req_q, ap_req_d;
    logic                   data_req_q, data_req_d;
    logic                   zero_q, zero_d;
    logic                   done_q, done_d;
    logic                   zero_flag_q, zero_flag_d;
    logic                   fault_q, fault_d;
    logic                   timeout;

    // Stepping ops (1..4) carry a repeat count; everything else is one-shot.
    function automatic logic is_step_op(input logic [2:0] op);
        return (op == OP_INC_DATA) || (op == OP_DEC_DATA) ||
               (op == OP_INC_AP)   || (op == OP_DEC_AP);
    endfunction

`ifdef APSEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    assign timeout = (wd_q == WD_W'(TIMEOUT_CYCLES));

    // Watchdog: restarts on every state change, counts only while blocked on Ready.
    always_comb begin
        wd_d = '0;
        if (state_d == state_q && (state_q == S_ISSUE || state_q == S_WAIT)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and output decode; pulses default low so each is one cycle wide.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        dec_d       = dec_q;
        zero_flag_d = zero_flag_q;
        fault_d     = fault_q;
        ap_req_d    = 1'b0;
        data_req_d  = 1'b0;
        zero_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CmdValid) begin
                    op_d        = CmdOp;
                    remaining_d = CmdCount;
                    dec_d       = (CmdOp == OP_DEC_DATA) || (CmdOp == OP_DEC_AP);
                    zero_flag_d = 1'b0;
                    fault_d     = 1'b0;
                    // A zero count skips ISSUE, so Remaining never wraps.
                    if ((is_step_op(CmdOp) && CmdCount != '0) ||
                        CmdOp == OP_ZERO || CmdOp == OP_TEST) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_ISSUE: begin
                if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (LineReady) begin
                    case (op_q)
                        OP_INC_DATA, OP_DEC_DATA: data_req_d = 1'b1;
                        OP_INC_AP, OP_DEC_AP:     ap_req_d   = 1'b1;
                        OP_ZERO:                  zero_d     = 1'b1;
                        default:                  ;
                    endcase
                    state_d = S_SETTLE;
                end
            end

            // One dead cycle so the line has time to drop Ready after the request.
            S_SETTLE: begin
                if (is_step_op(op_q)) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (LineReady) begin
                    if (op_q == OP_TEST) begin
                        zero_flag_d = DataZero;
                    end
                    if (is_step_op(op_q) && remaining_q != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                dec_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Done is registered so it appears exactly in the DONE cycle.
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            remaining_q <= '0;
            dec_q       <= 1'b0;
            ap_req_q    <= 1'b0;
            data_req_q  <= 1'b0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_flag_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            dec_q       <= dec_d;
            ap_req_q    <= ap_req_d;
            data_req_q  <= data_req_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
            zero_flag_q <= zero_flag_d;
            fault_q     <= fault_d;
        end
    end

    assign CmdReady    = (state_q == S_IDLE);
    assign ApRequest   = ap_req_q;
    assign DataRequest = data_req_q;
    assign Zero        = zero_q;
    assign Dec         = dec_q;
    assign Done        = done_q;
    assign ZeroFlag    = zero_flag_q;
    assign Fault       = fault_q;

endmodule
